// File: rtl/kanagawa_sim_fifo_pkg.sv
// rtl/kanagawa_sim_fifo_pkg.sv - sizing and pointer helpers shared by the kanagawa sim FIFOs
package kanagawa_sim_fifo_pkg;

    // A single-entry FIFO still needs a one-bit pointer.
    function automatic int ptr_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Wraps at depth, so depths that are not a power of two work.
    function automatic int wrap_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/kanagawa_sim_fifo_storage.sv
// rtl/kanagawa_sim_fifo_storage.sv - unreset DEPTH x WIDTH register array, one write port, async read
module kanagawa_sim_fifo_storage
    import kanagawa_sim_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int PW = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/kanagawa_sim_showahead_fifo.sv
// rtl/kanagawa_sim_showahead_fifo.sv - show-ahead FIFO with occupancy, almost-full and sticky error flags
module kanagawa_sim_showahead_fifo
    import kanagawa_sim_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 1,
    localparam int CW = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wrreq_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             full_out,
    output logic             almost_full_out,
    input  logic             rdreq_in,
    output logic             empty_out,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    count_out,
    output logic             overflow_out,
    output logic             underflow_out
);

    localparam int PW = ptr_width(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_COUNT   = CW'(ALMOST_FULL_LEVEL);

    if (DEPTH < 2 || ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_params
        $fatal(1, "kanagawa_sim_showahead_fifo: need DEPTH>=2 and 1<=ALMOST_FULL_LEVEL<=DEPTH");
    end

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
    logic             full;
    logic             empty;
    logic             push_acc;
    logic             pop_acc;
    logic             mem_we;
    logic [WIDTH-1:0] head;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // No full bypass: a pop in the same cycle never makes room for a push.
    assign push_acc = wrreq_in & ~full;
    assign pop_acc  = rdreq_in & ~empty;
    assign mem_we   = push_acc & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= PW'(wrap_inc(int'(wr_ptr), DEPTH));
            end
            if (pop_acc) begin
                rd_ptr <= PW'(wrap_inc(int'(rd_ptr), DEPTH));
            end
            case ({push_acc, pop_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wrreq_in && full) begin
                overflow <= 1'b1;
            end
            if (rdreq_in && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    kanagawa_sim_fifo_storage #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_storage (
        .clk  (clk),
        .we   (mem_we),
        .waddr(wr_ptr),
        .wdata(data_in),
        .raddr(rd_ptr),
        .rdata(head)
    );

    assign full_out        = full;
    assign empty_out       = empty;
    assign almost_full_out = (count >= AF_COUNT);
    assign count_out       = count;
    assign overflow_out    = overflow;
    assign underflow_out   = underflow;
    assign data_out        = empty ? '0 : head;

endmodule

// File: doc/kanagawa_sim_showahead_fifo.md
# kanagawa_sim_showahead_fifo

Synthesizable show-ahead (first-word-fall-through) FIFO. Its read side presents the rdreq/empty/data triple that the simulation FIFO-to-mailbox reader drains. It buffers items from any producer and gives benches a concrete, checkable queue in front of that reader. Occupancy, almost-full and sticky overflow/underflow flags feed bench assertions.

## Interface
Parameters:
- WIDTH, 32, item width in bits (≥1)
- DEPTH, 8, capacity in items (≥2, need not be a power of two)
- ALMOST_FULL_LEVEL, DEPTH-1, occupancy at or above which almost_full_out asserts (1..DEPTH)

Ports:
- clk  input  1  clock; all state on posedge
- rst  input  1  reset, asynchronous, active-high
- wrreq_in  input  1  push request
- data_in  input  WIDTH  push data
- full_out  output  1  count == DEPTH
- almost_full_out  output  1  count ≥ ALMOST_FULL_LEVEL
- rdreq_out-side: rdreq_in  input  1  pop request (head consumed this cycle)
- empty_out  output  1  count == 0
- data_out  output  WIDTH  head item; forced to 0 while empty_out
- count_out  output  CW  occupancy 0..DEPTH, CW = $clog2(DEPTH+1)
- overflow_out  output  1  sticky: push attempted while full
- underflow_out  output  1  sticky: pop attempted while empty

## Operation
- Storage: DEPTH-entry register array (not reset), wr_ptr, rd_ptr, count.
- Push accepted iff wrreq_in & ~full_out. Mem[wr_ptr] ← data_in. wr_ptr advances, wrapping DEPTH-1 → 0.
- Pop accepted iff rdreq_in & ~empty_out. rd_ptr advances with the same wrap rule.
- Full has no bypass. A push while full is dropped, even with an accepted pop in the same cycle, and overflow_out sets.
- Pop while empty is ignored; underflow_out sets. Same-cycle push to an empty FIFO does not satisfy the pop.
- count next = count + push_acc − pop_acc. Simultaneous accepted push and pop leave count unchanged.
- data_out = empty_out ? 0 : mem[rd_ptr]. Combinational from registered state, so there is no read latency.
- Sticky flags clear only on rst.
- Reset (async, any time, including mid-burst): pointers, count, overflow_out and underflow_out go to 0. Contents are discarded. Outputs go to empty_out=1, full_out=0, almost_full_out=0 (unless ALMOST_FULL_LEVEL would be 0, which is illegal), count_out=0, data_out=0.
- While rst is high, all requests are ignored and no flag sets.
- Elaboration-time check: DEPTH<2, or ALMOST_FULL_LEVEL outside 1..DEPTH → $fatal.

## Timing
- Push in cycle N: empty_out deasserts and data_out shows the item in cycle N+1.
- Pop in cycle N: the next item, or empty_out=1, appears in cycle N+1.
- All status outputs reflect registered state only. The sole combinational path is pointer → data_out mux.
- Back-to-back push and pop every cycle sustain 1 item/clk with constant count.
- Reset deassertion: the first push is accepted on the first posedge with rst low.

## Structure
- Package kanagawa_sim_fifo_pkg holds:
  - function ptr_width(depth) = max(1, $clog2(depth))
  - function count_width(depth) = $clog2(depth+1)
  - function wrap_inc(ptr, depth)
  These are shared with future FIFO variants.
- One sub-module: kanagawa_sim_fifo_storage. It is a DEPTH×WIDTH register array with a write port and an async read port, which keeps the control logic separate from the storage.

## Test plan
- Reset, then push 0xA1, 0xA2, 0xA3 on consecutive cycles with no pops. Required: data_out=0xA1 and count_out=1 one cycle after the first push; count_out=3 after the third push; empty_out=0.
- DEPTH=8, fill 8 items. Required: full_out=1 and almost_full_out (level 7) asserted from count 7. Then a 9th push with rdreq_in=1 in the same cycle. Required: the push is dropped, overflow_out=1, count_out=7.
- Pop while empty. Required: underflow_out=1, count_out stays 0, data_out=0. Assert a second pop. Required: the flag stays 1.
- DEPTH=5 (non-power-of-two), stream 20 items with simultaneous push and pop each cycle after priming one item. Required: order preserved across pointer wrap, count_out constant at 1.
- Assert rst asynchronously mid-stream with count_out=4 and overflow_out=1. Required: all outputs go to reset values before the next posedge. A push on the first cycle after deassertion gives count_out=1 next cycle.
